// File: rtl/tcb_gpio_irq_pkg.sv
// -----------------------------------------------------------------------------
// tcb_gpio_irq_pkg
//
// Shared definitions for the TCB GPIO interrupt controller:
//   - TCB bus widths and request/response payload structs
//   - register offsets of the event/interrupt block
//   - register-index enum and the address decoder that maps onto it
//   - width of the per-bit debounce counter
// -----------------------------------------------------------------------------
package tcb_gpio_irq_pkg;

    // TCB physical layer. The response is registered (one cycle of delay);
    // peripherals on this bus return read data on the cycle after the transfer.
    localparam int unsigned TCB_ABW = 32;
    localparam int unsigned TCB_DBW = 32;
    localparam int unsigned TCB_BEW = TCB_DBW / 8;

    typedef struct packed {
        logic               wen;  // 1: write, 0: read
        logic [TCB_ABW-1:0] adr;
        logic [TCB_BEW-1:0] ben;
        logic [TCB_DBW-1:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [TCB_DBW-1:0] rdt;
        logic               sts;
    } tcb_rsp_t;

    // Event/interrupt register offsets, decoded from adr[4:0].
    localparam logic [4:0] IRQ_ADR_INP = 5'h00;  // RO  filtered input
    localparam logic [4:0] IRQ_ADR_PND = 5'h04;  // W1C pending
    localparam logic [4:0] IRQ_ADR_MSK = 5'h08;  // RW  interrupt enable
    localparam logic [4:0] IRQ_ADR_RIS = 5'h0C;  // RW  rising-edge enable
    localparam logic [4:0] IRQ_ADR_FAL = 5'h10;  // RW  falling-edge enable
    localparam logic [4:0] IRQ_ADR_PRE = 5'h14;  // RW  prescaler reload

    typedef enum logic [2:0] {
        REG_INP,
        REG_PND,
        REG_MSK,
        REG_RIS,
        REG_FAL,
        REG_PRE,
        REG_NONE
    } irq_reg_e;

    // Debounce counter width; holds DBN-1 for DBN up to 15.
    localparam int unsigned DBN_CW = 4;

    // Word-aligned decode: the two byte-offset bits are ignored.
    function automatic irq_reg_e irq_reg_decode(input logic [4:0] adr);
        irq_reg_e idx;
        case ({adr[4:2], 2'b00})
            IRQ_ADR_INP: idx = REG_INP;
            IRQ_ADR_PND: idx = REG_PND;
            IRQ_ADR_MSK: idx = REG_MSK;
            IRQ_ADR_RIS: idx = REG_RIS;
            IRQ_ADR_FAL: idx = REG_FAL;
            IRQ_ADR_PRE: idx = REG_PRE;
            default:     idx = REG_NONE;
        endcase
        return idx;
    endfunction

endpackage : tcb_gpio_irq_pkg

// File: rtl/tcb_if.sv
// -----------------------------------------------------------------------------
// tcb_if
//
// TCB peripheral bus interface. Carries the bus clock and synchronous
// active-high reset alongside the handshake and payload.
//   clk, rst : clock and reset shared by manager and subordinate
//   vld      : manager request valid
//   rdy      : subordinate ready
//   trn      : transfer (vld & rdy)
//   req      : request payload (wen, adr, ben, wdt)
//   rsp      : response payload (rdt, sts), one cycle after the transfer
// -----------------------------------------------------------------------------
interface tcb_if
    import tcb_gpio_irq_pkg::*;
(
    input logic clk,
    input logic rst
);

    logic     vld;
    logic     rdy;
    logic     trn;
    tcb_req_t req;
    tcb_rsp_t rsp;

    assign trn = vld & rdy;

    modport man (input clk, rst, rdy, trn, rsp, output vld, req);
    modport sub (input clk, rst, vld, trn, req, output rdy, rsp);

endinterface : tcb_if

// File: rtl/tcb_gpio_irq_dbn.sv
// -----------------------------------------------------------------------------
// tcb_gpio_irq_dbn
//
// One-bit debounce filter. The output follows the input only after the input
// has differed from the output on DBN consecutive prescaler ticks; any return
// of the input to the output value restarts the count.
//   clk  : clock
//   rst  : synchronous active-high reset (output and counter to 0)
//   tick : prescaler tick, advances the counter
//   in   : synchronized input bit
//   out  : filtered output bit
// -----------------------------------------------------------------------------
module tcb_gpio_irq_dbn
    import tcb_gpio_irq_pkg::*;
#(
    parameter int unsigned DBN = 2
)(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in,
    output logic out
);

    logic [DBN_CW-1:0] cnt;

    // NOTE: flop updates use non-blocking assignments so every register
    // samples the values from before the clock edge, whatever the order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (in == out) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt == DBN_CW'(DBN - 1)) begin
                out <= in;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : tcb_gpio_irq_dbn

// File: rtl/tcb_gpio_irq.sv
// -----------------------------------------------------------------------------
// tcb_gpio_irq
//
// GPIO input event and interrupt controller on the TCB bus. Each input bit is
// debounced, edges of the filtered value are latched into W1C pending bits
// according to the rising/falling enables, and the masked OR of the pending
// bits drives a registered level interrupt.
//   GW  : GPIO width (1..32, not wider than the TCB data bus)
//   DBN : debounce length in prescaler ticks (1..15)
//   PW  : prescaler register width
//   tcb    : TCB subordinate port (clock, reset, registered response)
//   gpio_i : GPIO input, already synchronized to tcb.clk
//   irq    : interrupt request, registered, level, active-high
// -----------------------------------------------------------------------------
module tcb_gpio_irq
    import tcb_gpio_irq_pkg::*;
#(
    parameter int unsigned GW  = 32,
    parameter int unsigned DBN = 2,
    parameter int unsigned PW  = 16
)(
    tcb_if.sub             tcb,
    input  logic [GW-1:0]  gpio_i,
    output logic           irq
);

    // Bus decode
    irq_reg_e           idx;
    logic               wr;
    logic               rd;
    logic [GW-1:0]      wdt;
    logic [TCB_DBW-1:0] rdat;
    logic [TCB_DBW-1:0] rdt;

    // Registers
    logic [GW-1:0]      pnd;
    logic [GW-1:0]      msk;
    logic [GW-1:0]      ris;
    logic [GW-1:0]      fal;
    logic [PW-1:0]      pre;

    // Prescaler, filter and edge detection
    logic [PW-1:0]      pre_cnt;
    logic               tick;
    logic [GW-1:0]      flt;
    logic [GW-1:0]      flt_d;
    logic [GW-1:0]      rise;
    logic [GW-1:0]      fall;
    logic [GW-1:0]      set;
    logic [GW-1:0]      clr;

    // The subordinate never stalls and never reports an error.
    assign tcb.rdy = 1'b1;
    assign tcb.rsp = '{rdt: rdt, sts: 1'b0};

    assign idx = irq_reg_decode(tcb.req.adr[4:0]);
    assign wr  = tcb.trn &  tcb.req.wen;
    assign rd  = tcb.trn & ~tcb.req.wen;
    assign wdt = tcb.req.wdt[GW-1:0];

    // Byte enables are ignored (full-word writes) and only adr[4:2] selects.
    logic unused_bus;
    assign unused_bus = ^{tcb.req.ben, tcb.req.adr, tcb.req.wdt};

    // ------------------------------------------------------------------
    // Prescaler: down-counter, tick at zero, then reload. Writing PRE
    // restarts the count from the new value right away.
    // ------------------------------------------------------------------
    assign tick = (pre_cnt == '0);

    always_ff @(posedge tcb.clk) begin
        if (tcb.rst) begin
            pre_cnt <= '0;
        end else if (wr && idx == REG_PRE) begin
            pre_cnt <= tcb.req.wdt[PW-1:0];
        end else if (tick) begin
            pre_cnt <= pre;
        end else begin
            pre_cnt <= pre_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce filters
    // ------------------------------------------------------------------
    for (genvar i = 0; i < GW; i++) begin : g_dbn
        tcb_gpio_irq_dbn #(
            .DBN (DBN)
        ) u_dbn (
            .clk  (tcb.clk),
            .rst  (tcb.rst),
            .tick (tick),
            .in   (gpio_i[i]),
            .out  (flt[i])
        );
    end

    // ------------------------------------------------------------------
    // Edge detection and pending update. A set in the same cycle as a
    // W1C of the same bit wins, so no event is lost.
    // ------------------------------------------------------------------
    assign rise = flt & ~flt_d;
    assign fall = ~flt & flt_d;
    assign set  = (rise & ris) | (fall & fal);
    assign clr  = (wr && idx == REG_PND) ? wdt : '0;

    always_ff @(posedge tcb.clk) begin
        if (tcb.rst) begin
            flt_d <= '0;
            pnd   <= '0;
            irq   <= 1'b0;
        end else begin
            flt_d <= flt;
            pnd   <= (pnd & ~clr) | set;
            irq   <= |(pnd & msk);
        end
    end

    // ------------------------------------------------------------------
    // Writable control registers
    // ------------------------------------------------------------------
    always_ff @(posedge tcb.clk) begin
        if (tcb.rst) begin
            msk <= '0;
            ris <= '0;
            fal <= '0;
            pre <= '0;
        end else if (wr) begin
            case (idx)
                REG_MSK: msk <= wdt;
                REG_RIS: ris <= wdt;
                REG_FAL: fal <= wdt;
                REG_PRE: pre <= tcb.req.wdt[PW-1:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux, sampled at the transfer and returned on the next cycle.
    // PND reads the value held before this cycle's set/clear.
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rdat = '0;
        case (idx)
            REG_INP: rdat = TCB_DBW'(flt);
            REG_PND: rdat = TCB_DBW'(pnd);
            REG_MSK: rdat = TCB_DBW'(msk);
            REG_RIS: rdat = TCB_DBW'(ris);
            REG_FAL: rdat = TCB_DBW'(fal);
            REG_PRE: rdat = TCB_DBW'(pre);
            default: rdat = '0;
        endcase
    end

    always_ff @(posedge tcb.clk) begin
        if (tcb.rst) begin
            rdt <= '0;
        end else if (rd) begin
            rdt <= rdat;
        end
    end

endmodule : tcb_gpio_irq

// File: tb/tb_tcb_gpio_irq.sv
// -----------------------------------------------------------------------------
// tb_tcb_gpio_irq
//
// Self-checking bench for tcb_gpio_irq (GW=32, DBN=2, PW=16). A table of
// register write/read vectors covers the register file and address decode;
// hand-written sequences cover debounce, edge/pending/irq timing, W1C,
// set-vs-clear priority and reset.
// -----------------------------------------------------------------------------
module tb_tcb_gpio_irq;
    import tcb_gpio_irq_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] gpio;
    logic        irq;

    int unsigned n_cmp;
    int unsigned n_err;

    tcb_if tcb (.clk(clk), .rst(rst));

    tcb_gpio_irq #(
        .GW  (32),
        .DBN (2),
        .PW  (16)
    ) dut (
        .tcb    (tcb),
        .gpio_i (gpio),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        do_wr;
        logic [31:0] wadr;
        logic [31:0] wdat;
        logic [31:0] radr;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk);
        tcb.vld     = 1'b1;
        tcb.req.wen = 1'b1;
        tcb.req.adr = adr;
        tcb.req.wdt = dat;
        tcb.req.ben = '1;
        @(negedge clk);
        tcb.vld     = 1'b0;
        tcb.req.wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] adr, output logic [31:0] dat);
        @(negedge clk);
        tcb.vld     = 1'b1;
        tcb.req.wen = 1'b0;
        tcb.req.adr = adr;
        @(negedge clk);
        tcb.vld     = 1'b0;
        dat         = tcb.rsp.rdt;
    endtask

    logic [31:0] rd;
    vec_t        vecs [10];
    logic [31:0] regs [6];
    int          seen;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        gpio  = '0;
        tcb.vld = 1'b0;
        tcb.req = '0;

        vecs[0] = '{"msk rw",    1'b1, 32'h08, 32'hA5A5_0F0F, 32'h08, 32'hA5A5_0F0F};
        vecs[1] = '{"ris rw",    1'b1, 32'h0C, 32'h1234_5678, 32'h0C, 32'h1234_5678};
        vecs[2] = '{"fal rw",    1'b1, 32'h10, 32'hFFFF_0000, 32'h10, 32'hFFFF_0000};
        vecs[3] = '{"pre width", 1'b1, 32'h14, 32'hDEAD_BEEF, 32'h14, 32'h0000_BEEF};
        vecs[4] = '{"inp ro",    1'b1, 32'h00, 32'hFFFF_FFFF, 32'h00, 32'h0000_0000};
        vecs[5] = '{"pnd w1c 0", 1'b1, 32'h04, 32'hFFFF_FFFF, 32'h04, 32'h0000_0000};
        vecs[6] = '{"unmapped",  1'b1, 32'h18, 32'hFFFF_FFFF, 32'h18, 32'h0000_0000};
        vecs[7] = '{"alias wr",  1'b1, 32'h28, 32'h0000_00C3, 32'h08, 32'h0000_00C3};
        vecs[8] = '{"unmapped2", 1'b0, 32'h00, 32'h0000_0000, 32'h1C, 32'h0000_0000};
        vecs[9] = '{"alias rd",  1'b1, 32'h08, 32'h0000_0000, 32'h28, 32'h0000_0000};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state: all six registers and irq are zero.
        for (int i = 0; i < 6; i++) begin
            bus_read(32'(i * 4), rd);
            check($sformatf("reset reg 0x%02h", i * 4), rd, 32'h0);
        end
        check("reset irq", 32'(irq), 32'h0);

        // Register file and address decode.
        foreach (vecs[i]) begin
            if (vecs[i].do_wr) bus_write(vecs[i].wadr, vecs[i].wdat);
            bus_read(vecs[i].radr, rd);
            check(vecs[i].name, rd, vecs[i].exp);
        end
        bus_write(32'h0C, 32'h0);
        bus_write(32'h10, 32'h0);
        bus_write(32'h14, 32'h0);
        check("table irq", 32'(irq), 32'h0);

        // Rising edge on bit 0, PRE=0, DBN=2: flt after N+1, PND after N+2,
        // irq after N+3. PND is read every cycle (value before each edge).
        bus_write(32'h0C, 32'h1);
        bus_write(32'h08, 32'h1);
        @(negedge clk);
        gpio[0]     = 1'b1;
        tcb.vld     = 1'b1;
        tcb.req.wen = 1'b0;
        tcb.req.adr = 32'h04;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("rise pnd e%0d", i), tcb.rsp.rdt, (i == 4) ? 32'h1 : 32'h0);
            check($sformatf("rise irq e%0d", i), 32'(irq), (i == 4) ? 32'h1 : 32'h0);
        end
        tcb.vld = 1'b0;
        bus_read(32'h00, rd);
        check("rise inp", rd, 32'h1);

        // W1C: PND clears at the write edge, irq one edge later.
        @(negedge clk);
        tcb.vld     = 1'b1;
        tcb.req.wen = 1'b1;
        tcb.req.adr = 32'h04;
        tcb.req.wdt = 32'h1;
        @(negedge clk);
        tcb.vld     = 1'b0;
        tcb.req.wen = 1'b0;
        check("w1c irq at T", 32'(irq), 32'h1);
        @(negedge clk);
        check("w1c irq at T+1", 32'(irq), 32'h0);
        bus_read(32'h04, rd);
        check("w1c pnd", rd, 32'h0);

        // Glitch on bit 3 for one cycle never reaches the filter.
        bus_write(32'h0C, 32'h9);
        bus_write(32'h08, 32'h9);
        @(negedge clk);
        gpio[3] = 1'b1;
        @(negedge clk);
        gpio[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("glitch irq %0d", i), 32'(irq), 32'h0);
        end
        bus_read(32'h00, rd);
        check("glitch inp", rd, 32'h1);
        bus_read(32'h04, rd);
        check("glitch pnd", rd, 32'h0);

        // Falling edge on bit 7 with PRE=3: filter changes 5..8 edges after
        // the input change; masked off, so irq stays low until MSK is set.
        bus_write(32'h10, 32'h80);
        bus_write(32'h08, 32'h0);
        gpio[7] = 1'b1;
        repeat (6) @(negedge clk);
        bus_write(32'h14, 32'h3);
        repeat (10) @(negedge clk);
        @(negedge clk);
        gpio[7]     = 1'b0;
        tcb.vld     = 1'b1;
        tcb.req.wen = 1'b0;
        tcb.req.adr = 32'h00;
        seen = -1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (seen < 0 && tcb.rsp.rdt[7] == 1'b0) seen = j - 1;
        end
        tcb.vld = 1'b0;
        check("fal latency 5..8", 32'(seen >= 5 && seen <= 8), 32'h1);
        bus_read(32'h00, rd);
        check("fal inp", rd, 32'h1);
        bus_read(32'h04, rd);
        check("fal pnd", rd, 32'h80);
        check("fal irq masked", 32'(irq), 32'h0);
        @(negedge clk);
        tcb.vld     = 1'b1;
        tcb.req.wen = 1'b1;
        tcb.req.adr = 32'h08;
        tcb.req.wdt = 32'h80;
        @(negedge clk);
        tcb.vld     = 1'b0;
        tcb.req.wen = 1'b0;
        check("msk irq at T", 32'(irq), 32'h0);
        @(negedge clk);
        check("msk irq at T+1", 32'(irq), 32'h1);

        // W1C of bit 2 in the same cycle as a new bit-2 rising edge.
        bus_write(32'h14, 32'h0);
        bus_write(32'h10, 32'h0);
        bus_write(32'h04, 32'hFFFF_FFFF);
        bus_write(32'h08, 32'h4);
        bus_write(32'h0C, 32'h4);
        gpio[2] = 1'b1;
        repeat (6) @(negedge clk);
        check("sim first irq", 32'(irq), 32'h1);
        bus_read(32'h04, rd);
        check("sim first pnd", rd, 32'h4);
        gpio[2] = 1'b0;
        repeat (6) @(negedge clk);
        gpio[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tcb.vld     = 1'b1;
        tcb.req.wen = 1'b1;
        tcb.req.adr = 32'h04;
        tcb.req.wdt = 32'h4;
        @(negedge clk);
        tcb.vld     = 1'b0;
        tcb.req.wen = 1'b0;
        check("sim irq at T", 32'(irq), 32'h1);
        @(negedge clk);
        check("sim irq at T+1", 32'(irq), 32'h1);
        bus_read(32'h04, rd);
        check("sim pnd kept", rd, 32'h4);

        // Reset with PND=0xFF and irq high.
        gpio = '0;
        repeat (6) @(negedge clk);
        bus_write(32'h04, 32'hFFFF_FFFF);
        bus_write(32'h0C, 32'hFF);
        bus_write(32'h08, 32'hFF);
        gpio = 32'hFF;
        repeat (6) @(negedge clk);
        check("pre-rst irq", 32'(irq), 32'h1);
        bus_read(32'h04, rd);
        check("pre-rst pnd", rd, 32'hFF);
        @(negedge clk);
        rst  = 1'b1;
        gpio = 32'h1;
        @(negedge clk);
        rst  = 1'b0;
        check("rst irq", 32'(irq), 32'h0);
        for (int i = 1; i < 6; i++) begin
            bus_read(32'(i * 4), rd);
            regs[i] = rd;
            check($sformatf("rst reg 0x%02h", i * 4), regs[i], 32'h0);
        end
        repeat (4) @(negedge clk);
        bus_read(32'h00, rd);
        check("post-rst inp", rd, 32'h1);
        bus_read(32'h04, rd);
        check("post-rst no repend", rd, 32'h0);
        check("post-rst irq", 32'(irq), 32'h0);
        gpio = '0;
        repeat (6) @(negedge clk);
        bus_write(32'h0C, 32'h1);
        bus_write(32'h08, 32'h1);
        gpio = 32'h1;
        repeat (6) @(negedge clk);
        bus_read(32'h04, rd);
        check("repend pnd", rd, 32'h1);
        check("repend irq", 32'(irq), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tcb_gpio_irq

// File: doc/tcb_gpio_irq.md
# tcb_gpio_irq

GPIO input event and interrupt controller on the TCB peripheral bus, placed directly downstream of the GPIO controller's input path. It takes the synchronized GPIO input vector and filters it per bit with a debounce counter. It then detects rising and falling edges, latches them into write-1-to-clear pending bits and drives a single masked interrupt request to the CPU.

## Interface
- `GW`, 32: GPIO width, 1..32, must not exceed `tcb.PHY.DBW`.
- `DBN`, 2: debounce length in prescaler ticks, 1..15; 1 means filter output follows input one cycle later.
- `PW`, 16: prescaler register width.
- `tcb.clk`  input  1  clock (sole clock, carried in `tcb_if`).
- `tcb.rst`  input  1  reset, synchronous, active-high (carried in `tcb_if`).
- `tcb`  `tcb_if.sub`  -  TCB subordinate port, `PHY.DLY` must be 1.
- `gpio_i`  input  GW  GPIO input, already synchronized to `tcb.clk`.
- `irq`  output  1  interrupt request, registered, level, active-high.

## Operation
- Register map, decoded from `adr[5-1:0]`, word aligned:
  - 0x00 `INP`, RO: filtered input.
  - 0x04 `PND`, W1C: pending.
  - 0x08 `MSK`, RW: interrupt enable.
  - 0x0C `RIS`, RW: rising-edge enable.
  - 0x10 `FAL`, RW: falling-edge enable.
  - 0x14 `PRE`, RW, `PW` bits: prescaler reload.
- Other addresses read `'0`; writes to them and to `INP` are ignored. Unused upper data bits read 0.
- Reset values: `PND`, `MSK`, `RIS`, `FAL`, `PRE` = 0; prescaler counter = 0; debounce counters = 0; `flt` = 0; `irq` = 0.
- Prescaler: down-counter.
  - At 0 it asserts `tick` for one cycle and reloads `PRE`.
  - `PRE` = 0 gives a tick every cycle.
  - A write to `PRE` reloads the counter immediately.
- Debounce, per bit, 4-bit counter `cnt`:
  - If `gpio_i == flt`: `cnt` <= 0.
  - Else on `tick`: if `cnt == DBN-1`, then `flt` <= `gpio_i` and `cnt` <= 0; otherwise `cnt` <= `cnt`+1.
  - A glitch shorter than `DBN` ticks never reaches `flt`.
- Edge detection on `flt`, using a registered copy `flt_d`:
  - `rise = flt & ~flt_d`
  - `fall = ~flt & flt_d`
  - `set = (rise & RIS) | (fall & FAL)`
- Pending update: `PND` <= (`PND` & ~`clr`) | `set`.
  - `clr` is `wdt` on a write transfer to 0x04.
  - Set wins over a simultaneous clear of the same bit.
  - Writing 0 bits leaves them unchanged.
- `irq` <= |(`PND` & `MSK`). Clearing `MSK` does not clear `PND`.
- Handshake:
  - `tcb.rdy` is constantly 1, so every valid cycle is a transfer (`tcb.trn`).
  - `rsp.sts` is constantly 0.
  - Byte enables are ignored; writes are full-word.
- Read data:
  - Sampled at the transfer cycle and returned at DLY=1.
  - A read of `PND` returns the pre-update value, excluding same-cycle set and clear.

## Timing
- `gpio_i` change sampled at edge N, with `PRE`=0 and `DBN`=d: `flt` changes at edge N+d-1.
  - `PND` is set one edge after `flt` changes.
  - `irq` rises one edge after `PND`.
- With `PRE`=p: each debounce step waits p+1 cycles.
- W1C at transfer edge T: `PND` bit is 0 after T and `irq` is low after T+1, provided no other masked bit is pending.
- Register write at edge T is effective from cycle T+1.
  - This applies to `RIS`, `FAL` and `MSK`: an edge at T+1 uses the new enables.
- Reset asserted mid-debounce or with an interrupt pending clears everything at the next edge.
  - After release, `flt`=0. An input held high then produces a rising edge after `DBN` ticks.

## Structure
- Register address constants and the register-index enum go in the shared TCB peripheral package, next to the existing GPIO offsets.
- Sub-module `tcb_gpio_irq_dbn`: one-bit debounce filter with ports `clk`, `rst`, `tick`, `in`, `out`. Instantiated `GW` times in a generate loop.
- The prescaler, edge detection, register file and read mux stay in the top module.

## Test plan
- Reset, then read all six registers: every register returns 0 and `irq`=0.
- `PRE`=0, `DBN`=2, `RIS`=`MSK`=0x1, `gpio_i[0]` 0->1 held: `INP`=0x1 after 1 edge, `PND`=0x1 after 2 edges, `irq`=1 after 3 edges. Write 0x1 to 0x04: `PND`=0, `irq`=0 one cycle later.
- Glitch: `gpio_i[3]` high for 1 cycle with `DBN`=2: `INP`, `PND` and `irq` stay 0.
- `PRE`=3, `DBN`=2, `FAL`=0x80, `gpio_i[7]` 1->0 after settling: `INP[7]` clears 5–8 cycles after the change, depending on prescaler phase. `PND`=0x80, `MSK`=0 keeps `irq`=0; writing `MSK`=0x80 raises `irq` two edges later.
- Simultaneous W1C to bit 2 and a new bit-2 rising edge in the same cycle: `PND[2]` stays 1 and `irq` stays 1.
- Assert `rst` for 1 cycle with `PND`=0xFF and `irq`=1: all registers return 0 and `irq`=0 on the next edge. An input held at 0x1 re-pends only after `RIS` is re-enabled.
